// File: rtl/fixdiv_pkg.sv
// fixdiv_pkg: shared types and constant helpers for the fixed-point divider.
package fixdiv_pkg;

    localparam int DW_DEF = 8;
    localparam int FW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int cnt_w(input int dw, input int fw);
        return $clog2(dw + fw + 1);
    endfunction

    function automatic longint unsigned sat_max(input int dw);
        return (64'd1 << dw) - 64'd1;
    endfunction

endpackage

// File: rtl/fixdiv_if.sv
// fixdiv_if: operand/result valid-ready bundle of the fixed-point divider.
interface fixdiv_if #(
    parameter int DW = 8
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] z;
    logic          ovf;
    logic          dbz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, z, ovf, dbz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, z, ovf, dbz
    );
endinterface

// File: rtl/fixdiv_step.sv
// fixdiv_step: one restoring-division step (shift in a dividend bit, trial subtract).
module fixdiv_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem_i,
    input  logic          nbit_i,
    input  logic [DW-1:0] b_i,
    output logic [DW:0]   rem_o,
    output logic          qbit_o
);
    logic [DW+1:0] shift_s;

    // Shift and conditional subtract; the remainder stays below b between steps.
    always_comb begin
        shift_s = {rem_i, nbit_i};
        if (shift_s >= {2'b00, b_i}) begin
            qbit_o = 1'b1;
            rem_o  = shift_s[DW:0] - {1'b0, b_i};
        end else begin
            qbit_o = 1'b0;
            rem_o  = shift_s[DW:0];
        end
    end
endmodule

// File: rtl/fixdiv.sv
// fixdiv: sequential restoring divider, z = a*2^FW/b as unsigned fixed point, saturated.
// FIXDIV_ROUND_EN defined adds a ROUND state (nearest-even); undefined truncates.
module fixdiv
    import fixdiv_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int FW = FW_DEF
) (
    input  logic    clk,
    input  logic    rst,
    fixdiv_if.slave io
);
    localparam int            NW   = DW + FW;
    localparam int            CW   = cnt_w(DW, FW);
    localparam logic [DW-1:0] ZMAX = DW'(sat_max(DW));

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] nq_q, nq_d;     // dividend bits shift out the top, quotient bits in the bottom
    logic [DW-1:0] b_q, b_d;
    logic [DW:0]   rem_q, rem_d;
    logic [DW-1:0] z_q, z_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;
    logic          out_valid_q, out_valid_d;
    logic [DW:0]   rem_step_s;
    logic          qbit_s;
    logic          last_s;

    function automatic logic [DW:0] saturate(input logic [NW:0] v);
        logic [DW:0] r;
        if (v[NW:DW] != {(FW+1){1'b0}}) begin
            r = {1'b1, ZMAX};
        end else begin
            r = {1'b0, v[DW-1:0]};
        end
        return r;
    endfunction

    fixdiv_step #(.DW(DW)) u_step (
        .rem_i  (rem_q),
        .nbit_i (nq_q[NW-1]),
        .b_i    (b_q),
        .rem_o  (rem_step_s),
        .qbit_o (qbit_s)
    );

    assign last_s = (cnt_q == CW'(NW - 1));

`ifdef FIXDIV_ROUND_EN
    logic [DW+1:0] rem2_s;
    logic          rnd_up_s;
    logic [NW:0]   q_rnd_s;

    // Round half to even from the final remainder; the extra bit catches the carry.
    always_comb begin
        rem2_s = {rem_q, 1'b0};
        if (rem2_s > {2'b00, b_q}) begin
            rnd_up_s = 1'b1;
        end else if (rem2_s == {2'b00, b_q}) begin
            rnd_up_s = nq_q[0];
        end else begin
            rnd_up_s = 1'b0;
        end
        q_rnd_s = {1'b0, nq_q} + {{NW{1'b0}}, rnd_up_s};
    end
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nq_d        = nq_q;
        b_d         = b_q;
        rem_d       = rem_q;
        z_d         = z_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    nq_d  = {io.a, {FW{1'b0}}};
                    b_d   = io.b;
                    rem_d = {(DW+1){1'b0}};
                    cnt_d = {CW{1'b0}};
                    ovf_d = 1'b0;
                    dbz_d = 1'b0;
                    if (io.b == {DW{1'b0}}) begin
                        z_d         = ZMAX;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                nq_d  = {nq_q[NW-2:0], qbit_s};
                rem_d = rem_step_s;
                cnt_d = cnt_q + CW'(1);
                if (last_s) begin
`ifdef FIXDIV_ROUND_EN
                    state_d = ROUND;
`else
                    {ovf_d, z_d} = saturate({1'b0, nq_q[NW-2:0], qbit_s});
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            ROUND: begin
`ifdef FIXDIV_ROUND_EN
                {ovf_d, z_d} = saturate(q_rnd_s);
                out_valid_d  = 1'b1;
                state_d      = DONE;
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            nq_q        <= {NW{1'b0}};
            b_q         <= {DW{1'b0}};
            rem_q       <= {(DW+1){1'b0}};
            z_q         <= {DW{1'b0}};
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nq_q        <= nq_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            z_q         <= z_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.z         = z_q;
    assign io.ovf       = ovf_q;
    assign io.dbz       = dbz_q;
endmodule

// File: tb/tb_fixdiv.sv
// tb_fixdiv: directed scoreboard bench for fixdiv (DW=8, FW=4), either rounding build.
module tb_fixdiv;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [7:0] z;
        logic       ovf;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    fixdiv_if #(.DW(8)) io ();

    fixdiv #(.DW(8), .FW(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer division, then optional half-even rounding and saturation.
    // Latency counts clock edges after the accepting edge; b==0 finishes on that edge.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   n;
        int   q;
        int   r;
        if (b == 8'd0) begin
            e.z = 8'hFF; e.ovf = 1'b0; e.dbz = 1'b1; e.lat = 0;
            return e;
        end
        n = int'(a) * 16;
        q = n / int'(b);
        r = n % int'(b);
`ifdef FIXDIV_ROUND_EN
        if ((2 * r > int'(b)) || ((2 * r == int'(b)) && q[0])) q = q + 1;
        e.lat = 13;
`else
        e.lat = 12;
`endif
        e.dbz = 1'b0;
        if (q > 255) begin
            e.z = 8'hFF; e.ovf = 1'b1;
        end else begin
            e.z = 8'(q); e.ovf = 1'b0;
        end
        return e;
    endfunction

    // One operation from the current negedge; keep_valid leaves in_valid high with junk operands.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold, input bit keep_valid);
        exp_t e;
        int   lat;
        int   w;
        sb.push_back(model(a, b));
        io.a = a; io.b = b; io.in_valid = 1'b1; io.out_ready = 1'b0;
        w = 0;
        while (io.in_ready !== 1'b1 && w < 40) begin
            @(negedge clk); w++;
        end
        check("in_ready_before_accept", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_busy", 32'(io.in_ready), 32'd0);
        if (keep_valid) begin
            io.a = 8'hFF; io.b = 8'h01;
        end else begin
            io.in_valid = 1'b0;
        end
        lat = 0;
        while (io.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("out_valid", 32'(io.out_valid), 32'd1);
        check("pending_result", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("latency a=%0d b=%0d", a, b), 32'(lat), 32'(e.lat));
            check($sformatf("z a=%0d b=%0d", a, b), 32'(io.z), 32'(e.z));
            check($sformatf("ovf a=%0d b=%0d", a, b), 32'(io.ovf), 32'(e.ovf));
            check($sformatf("dbz a=%0d b=%0d", a, b), 32'(io.dbz), 32'(e.dbz));
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                check("hold_out_valid", 32'(io.out_valid), 32'd1);
                check("hold_in_ready", 32'(io.in_ready), 32'd0);
                check("hold_z", 32'(io.z), 32'(e.z));
                check("hold_flags", 32'({io.ovf, io.dbz}), 32'({e.ovf, e.dbz}));
            end
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(io.out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(io.in_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        io.in_valid = 1'b0; io.a = 8'd0; io.b = 8'd0; io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(io.in_ready), 32'd1);
        check("reset_out_valid", 32'(io.out_valid), 32'd0);
        check("reset_z", 32'(io.z), 32'd0);
        check("reset_flags", 32'({io.ovf, io.dbz}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd3,   8'd2,   0, 1'b0);
        run_op(8'd1,   8'd3,   0, 1'b0);
        run_op(8'd2,   8'd3,   0, 1'b0);
        run_op(8'd1,   8'd32,  0, 1'b0);
        run_op(8'd3,   8'd32,  0, 1'b0);
        run_op(8'd0,   8'd0,   0, 1'b0);
        run_op(8'd0,   8'd5,   0, 1'b0);
        run_op(8'd200, 8'd1,  10, 1'b0);
        run_op(8'd7,   8'd3,   0, 1'b1);
        run_op(8'd255, 8'd255, 0, 1'b1);
        run_op(8'd16,  8'd1,   0, 1'b1);
        run_op(8'd15,  8'd1,   0, 1'b0);
        run_op(8'd5,   8'd0,   3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 0, 1'b0);
        end

        // Abort an operation mid-RUN; the reset is asynchronous so check before any edge.
        io.a = 8'd9; io.b = 8'd4; io.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(io.in_ready), 32'd1);
        check("abort_out_valid", 32'(io.out_valid), 32'd0);
        check("abort_z", 32'(io.z), 32'd0);
        check("abort_flags", 32'({io.ovf, io.dbz}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (io.out_valid === 1'b1) seen = 1'b1;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        run_op(8'd3, 8'd2, 0, 1'b0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
